wptr_full_arb: RTL and testbench



---
 rtl/wptr_full_arb.sv | 104 ++++++++++
 tb/tb_wptr_full_arb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_arb.sv
// Write-side controller for the async FIFO: round-robin arbitration onto the
// single write port, binary/Gray write pointers, full, almost-full and level.
module wptr_full_arb #(
  parameter int unsigned ADDR   = 3,
  parameter int unsigned DATA   = 8,
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ALMOST = 2
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DATA-1:0] req_data,
  input  logic [ADDR:0]        wq2_rptr,
  output logic [NREQ-1:0]      gnt,
  output logic                 winc,
  output logic [ADDR-1:0]      waddr,
  output logic [DATA-1:0]      wdata,
  output logic [ADDR:0]        wptr,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ADDR:0]        wlevel
);

  localparam int unsigned NW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PW = ADDR + 1;
  localparam logic [PW-1:0] AF_THRESH = PW'((1 << ADDR) - ALMOST);

  logic [NW-1:0] rr_q, rr_d;
  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wgray_d;
  logic          wfull_q, wfull_d;
  logic          walmost_q, walmost_d;
  logic [PW-1:0] wlevel_q, wlevel_d;

  logic [NW-1:0] winner;
  logic [NW-1:0] idx;
  logic          any_req;
  logic          grant_ok;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rptr_full_cmp;

  // Round-robin search starting at rr_q; index arithmetic wraps mod NREQ.
  always_comb begin
    winner  = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = rr_q + NW'(k);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  assign grant_ok = wrst_n & any_req & ~wfull_q;
  assign gnt      = grant_ok ? (NREQ'(1) << winner) : '0;
  assign winc     = grant_ok;
  assign waddr    = wbin_q[ADDR-1:0];
  assign wdata    = req_data[DATA*32'(winner) +: DATA];

  // Gray-to-binary of the synchronized read pointer.
  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  assign rptr_full_cmp = {~wq2_rptr[ADDR:ADDR-1], wq2_rptr[ADDR-2:0]};

  always_comb begin
    wbin_d    = wbin_q + PW'(winc);
    wgray_d   = (wbin_d >> 1) ^ wbin_d;
    wfull_d   = (wgray_d == rptr_full_cmp);
    wlevel_d  = wbin_d - rbin;
    walmost_d = (wlevel_d >= AF_THRESH);
    rr_d      = winc ? (winner + NW'(1)) : rr_q;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rr_q      <= '0;
      wbin_q    <= '0;
      wptr_q    <= '0;
      wfull_q   <= 1'b0;
      walmost_q <= 1'b0;
      wlevel_q  <= '0;
    end else begin
      rr_q      <= rr_d;
      wbin_q    <= wbin_d;
      wptr_q    <= wgray_d;
      wfull_q   <= wfull_d;
      walmost_q <= walmost_d;
      wlevel_q  <= wlevel_d;
    end
  end

  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_q;
  assign wlevel       = wlevel_q;

endmodule

// File: tb/tb_wptr_full_arb.sv
// Scoreboard bench for wptr_full_arb: stimulus queues expected writes, a
// negedge monitor checks every memory write; state is checked inline.
module tb_wptr_full_arb;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  wq2_rptr;
  logic [3:0]  gnt;
  logic        winc;
  logic [2:0]  waddr;
  logic [7:0]  wdata;
  logic [3:0]  wptr;
  logic        wfull;
  logic        walmost_full;
  logic [3:0]  wlevel;

  wptr_full_arb #(.ADDR(3), .DATA(8), .NREQ(4), .ALMOST(2)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
    .wq2_rptr(wq2_rptr), .gnt(gnt), .winc(winc), .waddr(waddr),
    .wdata(wdata), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel)
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] dat_tab [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic push(input int r, input int a);
    exp_t e;
    e.gnt  = 4'(1 << r);
    e.addr = 3'(a);
    e.data = dat_tab[r];
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic hold_reset();
    wrst_n   = 1'b0;
    req      = 4'b0000;
    wq2_rptr = 4'h0;
    tick();
    tick();
  endtask

  // Monitor: every memory write must match the head of the expectation queue.
  always @(negedge wclk) begin
    if (winc === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: gnt=%b waddr=%0d wdata=%0h", gnt, waddr, wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("write_gnt", 32'(gnt), 32'(e.gnt));
        chk("write_waddr", 32'(waddr), 32'(e.addr));
        chk("write_wdata", 32'(wdata), 32'(e.data));
      end
    end
  end

  initial begin
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

    // Reset with all requesters asserted
    wrst_n   = 1'b0;
    req      = 4'b1111;
    wq2_rptr = 4'h0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_winc", 32'(winc), 32'h0);
    chk("rst_wptr", 32'(wptr), 32'h0);
    chk("rst_wfull", 32'(wfull), 32'h0);
    chk("rst_wlevel", 32'(wlevel), 32'h0);

    // Fill: grant order 0,1,2,3,0,1,2,3 at addresses 0..7
    for (int k = 0; k < 8; k++) push(k % 4, k);
    wrst_n = 1'b1;
    chk("rel_wptr", 32'(wptr), 32'h0);
    chk("rel_wfull", 32'(wfull), 32'h0);
    chk("rel_wlevel", 32'(wlevel), 32'h0);
    for (int k = 0; k < 8; k++) tick();
    chk("full_wfull", 32'(wfull), 32'h1);
    chk("full_wptr", 32'(wptr), 32'hC);
    chk("full_wlevel", 32'(wlevel), 32'h8);
    chk("full_almost", 32'(walmost_full), 32'h1);
    chk("full_gnt", 32'(gnt), 32'h0);
    tick();
    chk("full_hold_gnt", 32'(gnt), 32'h0);
    chk("full_hold_wptr", 32'(wptr), 32'hC);

    // Read pointer advances by one: exactly one more write, to requester 0
    push(0, 0);
    wq2_rptr = 4'b0001;
    tick();
    chk("unfull_wfull", 32'(wfull), 32'h0);
    chk("unfull_gnt", 32'(gnt), 32'h1);
    tick();
    chk("refull_wptr", 32'(wptr), 32'hD);
    chk("refull_wfull", 32'(wfull), 32'h1);
    chk("refull_wlevel", 32'(wlevel), 32'h8);

    // Almost-full threshold with a single requester
    hold_reset();
    wrst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      req = 4'b0001;
      push(0, k - 1);
      tick();
      chk("almost_level", 32'(wlevel), 32'(k));
      chk("almost_flag", 32'(walmost_full), (k >= 6) ? 32'h1 : 32'h0);
    end
    req = 4'b0000;

    // Round-robin skip: winner 2 moves the pointer to 3, then 0 beats 2
    hold_reset();
    wrst_n = 1'b1;
    req = 4'b0100;
    push(2, 0);
    tick();
    req = 4'b0101;
    push(0, 1);
    tick();
    req = 4'b0000;
    chk("rr_level", 32'(wlevel), 32'h2);
    chk("rr_wptr", 32'(wptr), 32'h3);

    // Pointer wrap with the read pointer trailing by two
    hold_reset();
    wrst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      req      = 4'b0001;
      wq2_rptr = (n >= 2) ? gtab[(n - 2) % 16] : 4'h0;
      push(0, (n - 1) % 8);
      tick();
      chk("wrap_wptr", 32'(wptr), 32'(gtab[n % 16]));
      chk("wrap_wfull", 32'(wfull), 32'h0);
      chk("wrap_wlevel", 32'(wlevel), (n < 2) ? 32'(n) : 32'h2);
      if (n == 15) chk("wrap_bin15", 32'(wptr), 32'h8);
      if (n == 16) chk("wrap_bin16", 32'(wptr), 32'h0);
    end
    req = 4'b0000;

    // Reset mid-operation after five writes
    hold_reset();
    wrst_n = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push(k % 4, k);
    for (int k = 0; k < 5; k++) tick();
    chk("mid_pre_wptr", 32'(wptr), 32'h7);
    #1;
    wrst_n = 1'b0;
    #1;
    chk("mid_rst_wptr", 32'(wptr), 32'h0);
    chk("mid_rst_wlevel", 32'(wlevel), 32'h0);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_winc", 32'(winc), 32'h0);
    tick();
    push(0, 0);
    wrst_n = 1'b1;
    #1;
    chk("mid_rel_gnt", 32'(gnt), 32'h1);
    tick();
    req = 4'b0000;
    chk("mid_rel_wlevel", 32'(wlevel), 32'h1);
    chk("mid_rel_wptr", 32'(wptr), 32'h1);

    tick();
    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
